// File: rtl/apb_slave_regfile.sv
// APB responder with a bank of word-addressed 32-bit registers, a read-only ID register at
// offset 0, a fixed number of wait states and PSLVERR for bad addresses or ID writes.
module apb_slave_regfile #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned NUM_REGS    = 16,
    parameter int unsigned WAIT_STATES = 2,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE = 32'hA0B0_0001
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic                  PWRITE,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR
);

    localparam int unsigned IDX_W     = $clog2(NUM_REGS);
    localparam logic [0:0]  StIdle    = 1'b0;
    localparam logic [0:0]  StAccess  = 1'b1;
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);

    logic [0:0]            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  write_q, write_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

    logic setup;
    logic setup_err;
    logic commit;
    logic access_done;

    assign setup = PSEL && !PENABLE;

    // Upper address bits must be zero, so aliases of the register window are rejected.
    assign setup_err = (PADDR[1:0] != 2'b00)
                    || (PADDR[ADDR_WIDTH-1:IDX_W+2] != '0)
                    || (PWRITE && (PADDR[IDX_W+1:2] == '0));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        write_d = write_q;
        err_d   = err_q;
        wdata_d = wdata_q;
        commit  = 1'b0;
        case (state_q)
            StIdle: begin
                if (setup) begin
                    state_d = StAccess;
                    cnt_d   = WAIT_INIT;
                    idx_d   = PADDR[IDX_W+1:2];
                    write_d = PWRITE;
                    err_d   = setup_err;
                    wdata_d = PWDATA;
                end
            end
            StAccess: begin
                if (!PSEL) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (PENABLE) begin
                    state_d = StIdle;
                    commit  = write_q && !err_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            write_q <= write_d;
            err_q   <= err_d;
            wdata_q <= wdata_d;
        end
    end

    // Entry 0 is never written; the ID value is substituted on read.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (commit) begin
            regs_q[idx_q] <= wdata_q;
        end
    end

    assign access_done = (state_q == StAccess) && (cnt_q == '0);

    always_comb begin
        PREADY  = access_done;
        PSLVERR = access_done && err_q;
        PRDATA  = '0;
        if (access_done && !write_q && !err_q) begin
            PRDATA = (idx_q == '0) ? ID_VALUE : regs_q[idx_q];
        end
    end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Bench for apb_slave_regfile: one instance with 0 and one with 2 wait states on a shared bus,
// expected responses queued at stimulus time and compared when PREADY rises.
module tb_apb_slave_regfile;

    localparam logic [31:0] ID = 32'hA0B0_0001;

    logic        pclk;
    logic        presetn;
    logic        psel0, psel2;
    logic        penable;
    logic [31:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [31:0] prdata0, prdata2;
    logic        pready0, pready2;
    logic        pslverr0, pslverr2;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int unsigned waits;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model [2][16];
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    apb_slave_regfile #(.WAIT_STATES(0)) u_dut_ws0 (
        .PCLK    (pclk),
        .PRESETn (presetn),
        .PSEL    (psel0),
        .PENABLE (penable),
        .PADDR   (paddr),
        .PWRITE  (pwrite),
        .PWDATA  (pwdata),
        .PRDATA  (prdata0),
        .PREADY  (pready0),
        .PSLVERR (pslverr0)
    );

    apb_slave_regfile #(.WAIT_STATES(2)) u_dut_ws2 (
        .PCLK    (pclk),
        .PRESETn (presetn),
        .PSEL    (psel2),
        .PENABLE (penable),
        .PADDR   (paddr),
        .PWRITE  (pwrite),
        .PWDATA  (pwdata),
        .PRDATA  (prdata2),
        .PREADY  (pready2),
        .PSLVERR (pslverr2)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic get_ready(input int d);
        return (d == 0) ? pready0 : pready2;
    endfunction

    function automatic logic get_err(input int d);
        return (d == 0) ? pslverr0 : pslverr2;
    endfunction

    function automatic logic [31:0] get_rdata(input int d);
        return (d == 0) ? prdata0 : prdata2;
    endfunction

    task automatic clear_model();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 16; i++) model[d][i] = '0;
    endtask

    task automatic bus_idle();
        @(posedge pclk); #1;
        psel0 = 1'b0; psel2 = 1'b0; penable = 1'b0;
    endtask

    // Leaves the bus in the access phase so a following call runs back-to-back.
    task automatic xfer(input int d, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data);
        exp_t e;
        logic err;
        int   idx;
        int   n;
        err     = (addr[1:0] != 2'b00) || (addr >= 32'd64) || (wr && addr == 32'd0);
        idx     = int'(addr[5:2]);
        e.err   = err;
        e.rdata = (!wr && !err) ? ((idx == 0) ? ID : model[d][idx]) : 32'd0;
        e.waits = (d == 0) ? 0 : 2;
        if (wr && !err) model[d][idx] = data;
        sb.push_back(e);

        @(posedge pclk); #1;
        psel0 = (d == 0); psel2 = (d != 0);
        penable = 1'b0; paddr = addr; pwrite = wr; pwdata = data;
        @(posedge pclk); #1;
        penable = 1'b1; paddr = ~addr; pwdata = ~data;
        n = 0;
        forever begin
            @(negedge pclk);
            if (get_ready(d)) break;
            check_val("wait_rdata", get_rdata(d), 32'd0);
            check_val("wait_slverr", 32'(get_err(d)), 32'd0);
            n++;
            if (n > 32) break;
        end
        e = sb.pop_front();
        check_val("wait_cycles", 32'(n), 32'(e.waits));
        check_val("rdata", get_rdata(d), e.rdata);
        check_val("slverr", 32'(get_err(d)), 32'(e.err));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        presetn = 1'b0; psel0 = 1'b0; psel2 = 1'b0; penable = 1'b0;
        paddr = '0; pwrite = 1'b0; pwdata = '0;
        clear_model();
        repeat (2) @(negedge pclk);
        check_val("rst_ready0", 32'(pready0), 32'd0);
        check_val("rst_ready2", 32'(pready2), 32'd0);
        check_val("rst_err0", 32'(pslverr0), 32'd0);
        check_val("rst_err2", 32'(pslverr2), 32'd0);
        check_val("rst_rdata0", prdata0, 32'd0);
        check_val("rst_rdata2", prdata2, 32'd0);
        presetn = 1'b1;

        // Two wait states
        xfer(1, 1'b1, 32'h4, 32'hDEAD_BEEF);
        xfer(1, 1'b0, 32'h4, 32'h0);
        bus_idle();

        // Zero wait states, ID register
        xfer(0, 1'b0, 32'h0, 32'h0);
        xfer(0, 1'b1, 32'h0, 32'h1234_5678);
        xfer(0, 1'b0, 32'h0, 32'h0);

        // Fill, then error transfers must not disturb anything
        for (int i = 1; i < 16; i++) xfer(0, 1'b1, 32'(4 * i), (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000);
        xfer(0, 1'b0, 32'h0000_0040, 32'h0);
        xfer(0, 1'b1, 32'h0000_0006, 32'hFFFF_FFFF);
        xfer(0, 1'b0, 32'h1000_0004, 32'h0);
        xfer(0, 1'b1, 32'h1000_0004, 32'hFFFF_FFFF);
        for (int i = 0; i < 16; i++) xfer(0, 1'b0, 32'(4 * i), 32'h0);
        bus_idle();

        // Back-to-back writes
        xfer(1, 1'b1, 32'h8, 32'h1111_1111);
        xfer(1, 1'b1, 32'hC, 32'h2222_2222);
        xfer(1, 1'b1, 32'h8, 32'h3333_3333);
        xfer(1, 1'b0, 32'h8, 32'h0);
        xfer(1, 1'b0, 32'hC, 32'h0);

        // Abort: PSEL drops at T1
        @(posedge pclk); #1;
        psel0 = 1'b0; psel2 = 1'b1; penable = 1'b0;
        paddr = 32'h10; pwrite = 1'b1; pwdata = 32'hCAFE_F00D;
        @(posedge pclk); #1;
        psel2 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge pclk);
            check_val("abort_ready", 32'(pready2), 32'd0);
        end
        xfer(1, 1'b0, 32'h10, 32'h0);
        bus_idle();

        // Reset while PRDATA is being driven
        @(posedge pclk); #1;
        psel2 = 1'b1; penable = 1'b0; paddr = 32'h4; pwrite = 1'b0;
        @(posedge pclk); #1;
        penable = 1'b1;
        repeat (2) @(posedge pclk);
        #1;
        check_val("t3_ready", 32'(pready2), 32'd1);
        check_val("t3_rdata", prdata2, 32'hDEAD_BEEF);
        presetn = 1'b0;
        #1;
        check_val("rst_async_ready", 32'(pready2), 32'd0);
        check_val("rst_async_rdata", prdata2, 32'd0);
        check_val("rst_async_err", 32'(pslverr2), 32'd0);
        clear_model();
        psel2 = 1'b0; penable = 1'b0;
        @(negedge pclk);
        presetn = 1'b1;

        // Reset during T2 of a write
        @(posedge pclk); #1;
        psel2 = 1'b1; penable = 1'b0; paddr = 32'h14; pwrite = 1'b1; pwdata = 32'hFFFF_FFFF;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #2;
        presetn = 1'b0;
        #1;
        check_val("rst_t2_ready", 32'(pready2), 32'd0);
        check_val("rst_t2_rdata", prdata2, 32'd0);
        check_val("rst_t2_err", 32'(pslverr2), 32'd0);
        psel2 = 1'b0; penable = 1'b0;
        @(posedge pclk);
        @(negedge pclk);
        presetn = 1'b1;
        xfer(1, 1'b0, 32'h14, 32'h0);
        xfer(1, 1'b1, 32'h14, 32'h5A5A_5A5A);
        xfer(1, 1'b0, 32'h14, 32'h0);
        bus_idle();

        check_val("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
